fifo_wr_arbiter: RTL and testbench

Round-robin write-side arbiter that shares the single write port of one `async_fifo` instance among `NUM_REQ` requesters in the write-clock domain. It grants one requester at a time for a burst of up to `MAX_BURST` beats and forwards accepted beats to the FIFO's `we_i`/`wdata_i`. It throttles all requesters on the FIFO's registered `full_o`. It sits between bus-side producers (e.g. a UART/SPI capture path and a CPU-written mailbox) and the FIFO.

---
 rtl/fifo_wr_arbiter.sv | 123 ++++++++++++
 tb/tb_fifo_wr_arbiter.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter sharing one async_fifo write port; FIFO_WR_ARB_TAG_EN prefixes each beat with its source index.
// Latency: grant one cycle after a request in IDLE; back-to-back bursts regrant on the last beat with no bubble.
// Backpressure: fifo_full_i gates the granted ready directly; grant and beat count hold until it drops.
module fifo_wr_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int WIDTH     = 32,
  parameter int MAX_BURST = 8,
  localparam int IDW      = $clog2(NUM_REQ),
`ifdef FIFO_WR_ARB_TAG_EN
  localparam int OW       = WIDTH + IDW
`else
  localparam int OW       = WIDTH
`endif
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic [NUM_REQ-1:0]       req_valid_i,
  input  logic [NUM_REQ*WIDTH-1:0] req_data_i,
  input  logic [NUM_REQ-1:0]       req_last_i,
  output logic [NUM_REQ-1:0]       req_ready_o,
  input  logic                     fifo_full_i,
  output logic                     fifo_we_o,
  output logic [OW-1:0]            fifo_wdata_o,
  output logic [NUM_REQ-1:0]       grant_o,
  output logic                     busy_o
);

  typedef enum logic {IDLE, GRANT} state_e;

  state_e             state_q;
  logic [NUM_REQ-1:0] grant_q;
  logic [IDW-1:0]     gidx_q;
  logic [IDW-1:0]     rr_ptr_q;
  logic [7:0]         cnt_q;

  logic [IDW-1:0]     idle_win;
  logic [IDW-1:0]     next_win;
  logic               idle_found;
  logic               next_found;
  logic               accept;
  logic               burst_end;
  logic [WIDTH-1:0]   gdata;

  // grant_q is zero in IDLE, so this also blocks acceptance there
  assign req_ready_o = grant_q & {NUM_REQ{~fifo_full_i}};
  assign fifo_we_o   = |(req_valid_i & req_ready_o);
  assign accept      = fifo_we_o;
  assign burst_end   = accept & (req_last_i[gidx_q] | (cnt_q == 8'(MAX_BURST - 1)));
  assign gdata       = req_data_i[int'(gidx_q)*WIDTH +: WIDTH];
  assign grant_o     = grant_q;
  assign busy_o      = (state_q == GRANT);

`ifdef FIFO_WR_ARB_TAG_EN
  assign fifo_wdata_o = {gidx_q, gdata};
`else
  assign fifo_wdata_o = gdata;
`endif

  // idle search covers everyone from rr_ptr+1; burst-end search skips the current owner
  always_comb begin
    idle_found = 1'b0;
    idle_win   = '0;
    next_found = 1'b0;
    next_win   = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      if (!idle_found && req_valid_i[(int'(rr_ptr_q) + i) % NUM_REQ]) begin
        idle_found = 1'b1;
        idle_win   = IDW'((int'(rr_ptr_q) + i) % NUM_REQ);
      end
    end
    for (int i = 1; i < NUM_REQ; i++) begin
      if (!next_found && req_valid_i[(int'(gidx_q) + i) % NUM_REQ]) begin
        next_found = 1'b1;
        next_win   = IDW'((int'(gidx_q) + i) % NUM_REQ);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      grant_q  <= '0;
      gidx_q   <= '0;
      rr_ptr_q <= IDW'(NUM_REQ - 1);
      cnt_q    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (idle_found) begin
            state_q  <= GRANT;
            grant_q  <= NUM_REQ'(1) << idle_win;
            gidx_q   <= idle_win;
            rr_ptr_q <= idle_win;
            cnt_q    <= '0;
          end
        end
        GRANT: begin
          if (burst_end) begin
            if (next_found) begin
              grant_q  <= NUM_REQ'(1) << next_win;
              gidx_q   <= next_win;
              rr_ptr_q <= next_win;
              cnt_q    <= '0;
            end else if (req_valid_i[gidx_q]) begin
              cnt_q <= '0;
            end else begin
              state_q <= IDLE;
              grant_q <= '0;
              cnt_q   <= '0;
            end
          end else if (accept) begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        default: begin
          state_q <= IDLE;
          grant_q <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter (NUM_REQ=4, WIDTH=32, MAX_BURST=8); honours FIFO_WR_ARB_TAG_EN.
module tb_fifo_wr_arbiter;

  localparam int NREQ = 4;
  localparam int W    = 32;
`ifdef FIFO_WR_ARB_TAG_EN
  localparam int OW   = W + 2;
`else
  localparam int OW   = W;
`endif
  localparam logic [63:0] OMASK = (64'd1 << OW) - 64'd1;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [NREQ-1:0]   req_valid = '0;
  logic [NREQ*W-1:0] req_data = '0;
  logic [NREQ-1:0]   req_last = '0;
  logic [NREQ-1:0]   ready;
  logic              fifo_full = 1'b0;
  logic              we;
  logic [OW-1:0]     wdata;
  logic [NREQ-1:0]   grant;
  logic              busy;

  logic [31:0] bdat  [4][32];
  logic        blast [4][32];
  int          blen  [4];
  int          bpos  [4];
  int          n_total = 0;
  int          n_bad   = 0;

  always #5 clk = ~clk;

  fifo_wr_arbiter #(.NUM_REQ(NREQ), .WIDTH(W), .MAX_BURST(8)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .req_valid_i(req_valid), .req_data_i(req_data), .req_last_i(req_last),
    .req_ready_o(ready), .fifo_full_i(fifo_full),
    .fifo_we_o(we), .fifo_wdata_o(wdata),
    .grant_o(grant), .busy_o(busy)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [63:0] ew(input int k, input logic [31:0] d);
    logic [63:0] r;
    r = {30'b0, k[1:0], d};
    return r & OMASK;
  endfunction

  task automatic drive();
    for (int k = 0; k < NREQ; k++) begin
      if (bpos[k] < blen[k]) begin
        req_valid[k]        = 1'b1;
        req_data[k*W +: W]  = bdat[k][bpos[k]];
        req_last[k]         = blast[k][bpos[k]];
      end else begin
        req_valid[k]        = 1'b0;
        req_data[k*W +: W]  = '0;
        req_last[k]         = 1'b0;
      end
    end
  endtask

  // last_mode: 0 none, 1 final beat, 2 every beat
  task automatic load(input int k, input int n, input logic [31:0] base, input int last_mode);
    for (int i = 0; i < n; i++) begin
      bdat[k][i]  = base + 32'(i);
      blast[k][i] = (last_mode == 2) || (last_mode == 1 && i == n - 1);
    end
    blen[k] = n;
    bpos[k] = 0;
  endtask

  task automatic reset_start();
    rst_n     = 1'b0;
    fifo_full = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      blen[k] = 0;
      bpos[k] = 0;
    end
    drive();
  endtask

  task automatic reset_release();
    drive();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // one cycle: retire beats handshaken before the edge, present new inputs, stop at the negedge
  task automatic tick(input logic f);
    logic [NREQ-1:0] acc;
    acc = req_valid & ready;
    @(posedge clk);
    #1;
    for (int k = 0; k < NREQ; k++)
      if (acc[k]) bpos[k]++;
    drive();
    fifo_full = f;
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1);
  end

  initial begin
    // reset values, then req0 and req2 bursts back to back
    reset_start();
    load(0, 3, 32'hA0, 1);
    load(2, 3, 32'hC0, 1);
    drive();
    @(negedge clk);
    chk("rst_grant", 64'(grant), 64'h0);
    chk("rst_busy",  64'(busy),  64'h0);
    chk("rst_ready", 64'(ready), 64'h0);
    chk("rst_we",    64'(we),    64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick(1'b0);
      chk("s1_grant0", 64'(grant), 64'h1);
      chk("s1_we0",    64'(we),    64'h1);
      chk("s1_dat0",   64'(wdata), ew(0, 32'hA0 + 32'(i)));
    end
    chk("s1_busy", 64'(busy), 64'h1);
    for (int i = 0; i < 3; i++) begin
      tick(1'b0);
      chk("s1_grant2", 64'(grant), 64'h4);
      chk("s1_we2",    64'(we),    64'h1);
      chk("s1_dat2",   64'(wdata), ew(2, 32'hC0 + 32'(i)));
    end
    tick(1'b0);
    chk("s1_hold_grant", 64'(grant), 64'h4);
    chk("s1_hold_we",    64'(we),    64'h0);
    chk("s1_hold_busy",  64'(busy),  64'h1);

    // all four continuously valid without last: 8-beat rotation 0,1,2,3,0
    reset_start();
    for (int k = 0; k < NREQ; k++) load(k, 16, 32'(k << 8), 0);
    reset_release();
    for (int c = 0; c < 40; c++) begin
      tick(1'b0);
      chk("s2_grant", 64'(grant), 64'(1 << ((c / 8) % 4)));
      chk("s2_we",    64'(we),    64'h1);
      chk("s2_dat",   64'(wdata), ew((c / 8) % 4, 32'((((c / 8) % 4) << 8) | ((c / 32) * 8 + c % 8))));
    end

    // full for 5 cycles at beat 2; count must hold so req0 still gets 8 beats
    reset_start();
    load(0, 10, 32'hB0, 0);
    load(1, 2, 32'hD0, 1);
    reset_release();
    tick(1'b0);
    chk("s3_b0", 64'(wdata), ew(0, 32'hB0));
    tick(1'b0);
    chk("s3_b1", 64'(wdata), ew(0, 32'hB1));
    for (int i = 0; i < 5; i++) begin
      tick(1'b1);
      chk("s3_full_we",    64'(we),    64'h0);
      chk("s3_full_ready", 64'(ready), 64'h0);
      chk("s3_full_grant", 64'(grant), 64'h1);
    end
    for (int i = 2; i < 8; i++) begin
      tick(1'b0);
      chk("s3_grant", 64'(grant), 64'h1);
      chk("s3_we",    64'(we),    64'h1);
      chk("s3_dat",   64'(wdata), ew(0, 32'hB0 + 32'(i)));
    end
    tick(1'b0);
    chk("s3_switch_grant", 64'(grant), 64'h2);
    chk("s3_switch_dat",   64'(wdata), ew(1, 32'hD0));

    // lone requester with single-beat bursts
    reset_start();
    load(1, 4, 32'hE0, 2);
    reset_release();
    for (int i = 0; i < 4; i++) begin
      tick(1'b0);
      chk("s4_grant", 64'(grant), 64'h2);
      chk("s4_we",    64'(we),    64'h1);
      chk("s4_dat",   64'(wdata), ew(1, 32'hE0 + 32'(i)));
    end
    tick(1'b0);
    chk("s4_idle_we", 64'(we), 64'h0);

    // reset during beat 4 of 8
    reset_start();
    load(0, 8, 32'hF0, 1);
    load(1, 1, 32'h0AB0, 1);
    reset_release();
    for (int i = 0; i < 5; i++) begin
      tick(1'b0);
      chk("s5_grant", 64'(grant), 64'h1);
      chk("s5_dat",   64'(wdata), ew(0, 32'hF0 + 32'(i)));
    end
    #1 rst_n = 1'b0;
    #1;
    chk("s5_rst_grant", 64'(grant), 64'h0);
    chk("s5_rst_we",    64'(we),    64'h0);
    chk("s5_rst_ready", 64'(ready), 64'h0);
    chk("s5_rst_busy",  64'(busy),  64'h0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    tick(1'b0);
    chk("s5_after_grant", 64'(grant), 64'h1);
    chk("s5_after_dat",   64'(wdata), ew(0, 32'hF4));

    // req3 beat, tagged with index 3 when the tag build is enabled
    reset_start();
    load(3, 1, 32'h12345678, 1);
    reset_release();
    tick(1'b0);
    chk("s6_grant", 64'(grant), 64'h8);
`ifdef FIFO_WR_ARB_TAG_EN
    chk("s6_tag_dat", 64'(wdata), 64'h3_1234_5678);
`else
    chk("s6_dat", 64'(wdata), 64'h0_1234_5678);
`endif

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
